// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the input debouncer.
// Channel counts match the button peripheral's push_i/switch_i buses.
package debounce_pkg;

    localparam int N_PUSH_DEFAULT       = 10;
    localparam int N_SWITCH_DEFAULT     = 8;
    localparam int N_CHAN_DEFAULT       = N_PUSH_DEFAULT + N_SWITCH_DEFAULT;
    localparam int TICK_DIV_DEFAULT     = 50000;
    localparam int STABLE_TICKS_DEFAULT = 8;
    localparam int SYNC_STAGES_DEFAULT  = 2;

    typedef logic [$clog2(N_CHAN_DEFAULT)-1:0] chan_idx_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: synchroniser chain, stability counter, output flop.
// With CHANGE_PULSE_EN defined, also a one-cycle change pulse.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int   SYNC_STAGES  = SYNC_STAGES_DEFAULT,
    parameter logic IDLE         = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    input  logic tick_i,
    output logic out_o
`ifdef CHANGE_PULSE_EN
    ,
    output logic changed_o
`endif
);

    localparam int CW = cnt_width(STABLE_TICKS + 1);
    localparam logic [CW:0] LAST = (CW + 1)'(STABLE_TICKS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW:0]            cnt_inc;
    logic                   sync;
    logic                   differ;
    logic                   accept;

    assign sync    = sync_q[SYNC_STAGES-1];
    assign differ  = sync ^ out_o;
    assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);
    assign accept  = tick_i & differ & (cnt_inc == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{IDLE}};
            out_o  <= IDLE;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            if (tick_i) begin
                // Any tick agreeing with the output restarts the run.
                if (!differ) begin
                    cnt_q <= '0;
                end else if (accept) begin
                    out_o <= sync;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_inc[CW-1:0];
                end
            end
        end
    end

`ifdef CHANGE_PULSE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            changed_o <= 1'b0;
        end else begin
            changed_o <= accept;
        end
    end
`endif

endmodule

// File: rtl/input_debouncer.sv
// Synchronise and debounce raw push/switch pins for the button peripheral.
// Optional macro CHANGE_PULSE_EN adds the changed_o per-bit change pulse.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int N_PUSH       = N_PUSH_DEFAULT,
    parameter int N_SWITCH     = N_SWITCH_DEFAULT,
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT,
    parameter logic [N_PUSH-1:0]   PUSH_IDLE   = '0,
    parameter logic [N_SWITCH-1:0] SWITCH_IDLE = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_PUSH-1:0]            push_raw_i,
    input  logic [N_SWITCH-1:0]          switch_raw_i,
    output logic [N_PUSH-1:0]            push_o,
    output logic [N_SWITCH-1:0]          switch_o
`ifdef CHANGE_PULSE_EN
    ,
    output logic [N_PUSH+N_SWITCH-1:0]   changed_o
`endif
);

    localparam int N  = N_PUSH + N_SWITCH;
    localparam int PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] DIV_MAX = PW'(TICK_DIV - 1);
    localparam logic [N-1:0]  IDLE_VEC = {SWITCH_IDLE, PUSH_IDLE};

    logic [PW-1:0] div_q;
    logic          tick;
    logic [N-1:0]  raw;
    logic [N-1:0]  out;

    assign raw  = {switch_raw_i, push_raw_i};
    assign tick = (div_q == DIV_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + PW'(1);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .SYNC_STAGES  (SYNC_STAGES),
            .IDLE         (IDLE_VEC[i])
        ) u_chan (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .raw_i     (raw[i]),
            .tick_i    (tick),
            .out_o     (out[i])
`ifdef CHANGE_PULSE_EN
            ,
            .changed_o (changed_o[i])
`endif
        );
    end

    assign push_o   = out[N_PUSH-1:0];
    assign switch_o = out[N-1:N_PUSH];

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with a tick-sampling reference model.
// Small parameters keep every scenario within a few hundred cycles.
module tb_input_debouncer;

    localparam int NP = 10;
    localparam int NS = 8;
    localparam int N  = NP + NS;
    localparam int TD = 4;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NP-1:0] push_raw = '0;
    logic [NS-1:0] sw_raw = '0;
    logic [NP-1:0] push_o;
    logic [NS-1:0] switch_o;
    logic [N-1:0]  dvec;
`ifdef CHANGE_PULSE_EN
    logic [N-1:0]  changed;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    input_debouncer #(
        .N_PUSH       (NP),
        .N_SWITCH     (NS),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .SYNC_STAGES  (2),
        .PUSH_IDLE    (10'h000),
        .SWITCH_IDLE  (8'h00)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .push_raw_i   (push_raw),
        .switch_raw_i (sw_raw),
        .push_o       (push_o),
        .switch_o     (switch_o)
`ifdef CHANGE_PULSE_EN
        ,
        .changed_o    (changed)
`endif
    );

    assign dvec = {switch_o, push_o};

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got,
                               input int lo, input int hi);
        n_cmp++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Counts rising clock edges until bit idx shows lvl; -1 on timeout.
    task automatic wait_level(input int idx, input logic lvl, input int maxc,
                              output int cyc);
        cyc = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(posedge clk);
            #1;
            if (dvec[idx] === lvl) begin
                cyc = k;
                break;
            end
        end
    endtask

    // Reference model: pins reach the sampler two edges late; every TD-th
    // edge after reset release samples them; a level is accepted once the
    // last ST samples since the previous acceptance all disagree with it.
    logic [N-1:0]  s0 = '0;
    logic [N-1:0]  s1 = '0;
    logic [N-1:0]  mout = '0;
    logic [N-1:0]  mchg = '0;
    logic [31:0]   hist [N];
    int            since [N];
    int            edges = 0;

    initial begin
        logic [31:0] mask;
        mask = (32'd1 << ST) - 32'd1;
        for (int c = 0; c < N; c++) begin
            hist[c] = '0;
            since[c] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                s0 = '0;
                s1 = '0;
                mout = '0;
                mchg = '0;
                edges = 0;
                for (int c = 0; c < N; c++) begin
                    hist[c] = '0;
                    since[c] = 0;
                end
            end else begin
                edges++;
                mchg = '0;
                if (edges % TD == 0) begin
                    for (int c = 0; c < N; c++) begin
                        hist[c] = {hist[c][30:0], s1[c] != mout[c]};
                        since[c]++;
                        if (since[c] >= ST && (hist[c] & mask) == mask) begin
                            mout[c] = ~mout[c];
                            mchg[c] = 1'b1;
                            hist[c] = '0;
                            since[c] = 0;
                        end
                    end
                end
                s1 = s0;
                s0 = {sw_raw, push_raw};
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("model_out", 32'(dvec), 32'(mout));
`ifdef CHANGE_PULSE_EN
        check("model_chg", 32'(changed), 32'(mchg));
`endif
    end

    initial begin
        int c;
        logic seen;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_push", 32'(push_o), 32'h000);
        check("reset_switch", 32'(switch_o), 32'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Clean press on push 0.
        push_raw[0] = 1'b1;
        wait_level(0, 1'b1, 20, c);
        check_range("press_latency", c, 11, 14);
        check("press_only_bit0", 32'(dvec), 32'h00001);

        // Bounce on push 3, then a steady high.
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            push_raw[3] = ~push_raw[3];
            for (int j = 0; j < 5; j++) begin
                @(posedge clk);
                #1;
                if (dvec[3]) seen = 1'b1;
            end
        end
        check("bounce_quiet", 32'(seen), 32'd0);
        @(negedge clk);
        push_raw[3] = 1'b1;
        wait_level(3, 1'b1, 20, c);
        check_range("bounce_settle", c, 11, 14);

        // Switch 7 accepted high, then released.
        @(negedge clk);
        sw_raw[7] = 1'b1;
        wait_level(N - 1, 1'b1, 20, c);
        check_range("switch_rise", c, 11, 14);
        @(negedge clk);
        sw_raw[7] = 1'b0;
        wait_level(N - 1, 1'b0, 20, c);
        check_range("switch_fall", c, 11, 14);
        check("switch_low_bits", 32'(switch_o[6:0]), 32'h00);

        // Reset in the middle of a stability run.
        @(negedge clk);
        push_raw = '0;
        sw_raw = '0;
        repeat (20) @(negedge clk);
        check("idle_before_mid", 32'(dvec), 32'h0);
        push_raw[5] = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_not_yet", 32'(push_o[5]), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_level(5, 1'b1, 20, c);
        check("reset_recount", c, 12);

        // All channels rise together.
        @(negedge clk);
        push_raw = '0;
        sw_raw = '0;
        repeat (20) @(negedge clk);
        check("idle_before_all", 32'(dvec), 32'h0);
        push_raw = '1;
        sw_raw = '1;
        c = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (dvec != '0) begin
                c = k;
                break;
            end
        end
        check_range("all_latency", c, 11, 14);
        check("all_push", 32'(push_o), 32'h3FF);
        check("all_switch", 32'(switch_o), 32'hFF);
`ifdef CHANGE_PULSE_EN
        check("all_changed", 32'(changed), 32'h3FFFF);
        @(posedge clk);
        #1;
        check("all_changed_clear", 32'(changed), 32'h0);
`endif

        // Asynchronous reset between edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_push", 32'(push_o), 32'h000);
        check("async_switch", 32'(switch_o), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
